// File: rtl/wmem_load_seq.sv
// Streaming weight/bias loader: turns one command plus a 32-bit word stream into
// single-cycle entry writes on the conv1/conv2/fc memory ports, walking the address map.
module wmem_load_seq #(
  parameter int CONV1_BANK_BW   = 3,
  parameter int CONV1_ADDR_BW   = 3,
  parameter int CONV1_VECTOR_BW = 104,
  parameter int CONV2_BANK_BW   = 3,
  parameter int CONV2_ADDR_BW   = 4,
  parameter int CONV2_VECTOR_BW = 64,
  parameter int FC_BANK_BW      = 2,
  parameter int FC_ADDR_BW      = 8,
  parameter int FC_BIAS_BW      = 32,
  parameter int COUNT_BW        = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [11:0]                cmd_addr_i,
  input  logic [COUNT_BW-1:0]        cmd_count_i,
  input  logic                       word_valid_i,
  output logic                       word_ready_o,
  input  logic [31:0]                word_data_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       conv1_wr_en_o,
  output logic [CONV1_BANK_BW-1:0]   conv1_wr_bank_o,
  output logic [CONV1_ADDR_BW-1:0]   conv1_wr_addr_o,
  output logic [CONV1_VECTOR_BW-1:0] conv1_wr_data_o,
  output logic                       conv2_wr_en_o,
  output logic [CONV2_BANK_BW-1:0]   conv2_wr_bank_o,
  output logic [CONV2_ADDR_BW-1:0]   conv2_wr_addr_o,
  output logic [CONV2_VECTOR_BW-1:0] conv2_wr_data_o,
  output logic                       fc_wr_en_o,
  output logic [FC_BANK_BW-1:0]      fc_wr_bank_o,
  output logic [FC_ADDR_BW-1:0]      fc_wr_addr_o,
  output logic [FC_BIAS_BW-1:0]      fc_wr_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  function automatic logic addr_valid(input logic [11:0] a);
    logic ok;
    ok = 1'b0;
    case (a[11:8])
      4'h0: ok = (a[7:6] == 2'b00 && a[3] == 1'b0) || (a == 12'h040) ||
                 (a[7:4] >= 4'h5 && a[7:4] <= 4'h8) || (a == 12'h090);
      4'h1, 4'h2: ok = (a[7:0] <= 8'hCF);
      4'h3, 4'h4: ok = (a[7:0] == 8'h00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Returns {end_flag, next_addr}; only ever called with an address inside the map.
  function automatic logic [12:0] next_addr(input logic [11:0] a);
    logic [12:0] nxt;
    nxt = {1'b0, a + 12'd1};
    if (a[11:8] == 4'h0) begin
      if (a[7:6] == 2'b00) begin
        if (a[2:0] == 3'h7)
          nxt = (a[5:4] == 2'd3) ? 13'h040 : {1'b0, 4'h0, 2'b00, a[5:4] + 2'd1, 4'h0};
      end else if (a == 12'h040) begin
        nxt = 13'h050;
      end else if (a == 12'h090) begin
        nxt = 13'h100;
      end else if (a[3:0] == 4'hF) begin
        nxt = (a[7:4] == 4'h8) ? 13'h090 : {1'b0, a[11:8], a[7:4] + 4'd1, 4'h0};
      end
    end else if (a[11:8] == 4'h1 || a[11:8] == 4'h2) begin
      if (a[7:0] == 8'hCF) nxt = {1'b0, a[11:8] + 4'd1, 8'h00};
    end else if (a == 12'h300) begin
      nxt = 13'h400;
    end else begin
      nxt = 13'h1000;
    end
    return nxt;
  endfunction

  state_t               state_q, state_d;
  logic [11:0]          addr_q;
  logic [COUNT_BW-1:0]  count_q;
  logic [1:0]           idx_q;
  logic [31:0]          slot0_q, slot1_q, slot2_q;
  logic [7:0]           slot3_q;
  logic                 err_q, err_d;

  logic                 is_fc, is_conv1, is_conv2;
  logic [1:0]           last_idx;
  logic [12:0]          nxt;
  logic                 cmd_ok;
  logic                 word_fire;

  assign is_fc    = (addr_q[11:8] != 4'h0);
  assign is_conv1 = !is_fc && (addr_q[7:0] < 8'h50);
  assign is_conv2 = !is_fc && !is_conv1;
  assign last_idx = is_conv1 ? 2'd3 : (is_fc ? 2'd0 : 2'd1);
  assign nxt      = next_addr(addr_q);
  assign cmd_ok   = addr_valid(cmd_addr_i) && (cmd_count_i != '0);

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign word_ready_o = (state_q == S_COLLECT);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = err_q;
  assign word_fire    = word_valid_i && word_ready_o;

  assign conv1_wr_en_o   = (state_q == S_WRITE) && is_conv1;
  assign conv1_wr_bank_o = CONV1_BANK_BW'(addr_q[6:4]);
  assign conv1_wr_addr_o = CONV1_ADDR_BW'(addr_q[2:0]);
  assign conv1_wr_data_o = CONV1_VECTOR_BW'({slot3_q, slot2_q, slot1_q, slot0_q});

  // conv2 banks start at row 5 of the map, so the subtraction wraps 0x08x to bank 3.
  assign conv2_wr_en_o   = (state_q == S_WRITE) && is_conv2;
  assign conv2_wr_bank_o = CONV2_BANK_BW'(addr_q[6:4] - 3'd5);
  assign conv2_wr_addr_o = CONV2_ADDR_BW'(addr_q[3:0]);
  assign conv2_wr_data_o = CONV2_VECTOR_BW'({slot1_q, slot0_q});

  assign fc_wr_en_o      = (state_q == S_WRITE) && is_fc;
  assign fc_wr_bank_o    = FC_BANK_BW'(addr_q[11:8] - 4'd1);
  assign fc_wr_addr_o    = FC_ADDR_BW'(addr_q[7:0]);
  assign fc_wr_data_o    = FC_BIAS_BW'(slot0_q);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_ok) state_d = S_COLLECT;
          else        err_d   = 1'b1;
        end
      end
      S_COLLECT: begin
        if (word_fire && idx_q == last_idx) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (count_q == COUNT_BW'(1)) begin
          state_d = S_DONE;
        end else if (nxt[12]) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the holding slots are plain flops, not a RAM, so they are cleared on reset and a stale entry never leaks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
      slot2_q <= '0;
      slot3_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ok) begin
            addr_q  <= cmd_addr_i;
            count_q <= cmd_count_i;
            idx_q   <= '0;
          end
        end
        S_COLLECT: begin
          if (word_fire) begin
            case (idx_q)
              2'd0: slot0_q <= word_data_i;
              2'd1: slot1_q <= word_data_i;
              2'd2: slot2_q <= word_data_i;
              default: slot3_q <= word_data_i[7:0];
            endcase
            idx_q <= idx_q + 2'd1;
          end
        end
        S_WRITE: begin
          count_q <= count_q - COUNT_BW'(1);
          idx_q   <= '0;
          if (!nxt[12]) addr_q <= nxt[11:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wmem_load_seq.sv
// Directed self-checking bench for wmem_load_seq: a negedge monitor logs every write,
// done/err pulse and word handshake; each test compares the log with hand-computed values.
module tb_wmem_load_seq;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [11:0]  cmd_addr_i;
  logic [9:0]   cmd_count_i;
  logic         word_valid_i;
  logic         word_ready_o;
  logic [31:0]  word_data_i;
  logic         busy_o, done_o, err_o;
  logic         conv1_wr_en_o;
  logic [2:0]   conv1_wr_bank_o;
  logic [2:0]   conv1_wr_addr_o;
  logic [103:0] conv1_wr_data_o;
  logic         conv2_wr_en_o;
  logic [2:0]   conv2_wr_bank_o;
  logic [3:0]   conv2_wr_addr_o;
  logic [63:0]  conv2_wr_data_o;
  logic         fc_wr_en_o;
  logic [1:0]   fc_wr_bank_o;
  logic [7:0]   fc_wr_addr_o;
  logic [31:0]  fc_wr_data_o;

  wmem_load_seq dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_count_i(cmd_count_i),
    .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .word_data_i(word_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .conv1_wr_en_o(conv1_wr_en_o), .conv1_wr_bank_o(conv1_wr_bank_o),
    .conv1_wr_addr_o(conv1_wr_addr_o), .conv1_wr_data_o(conv1_wr_data_o),
    .conv2_wr_en_o(conv2_wr_en_o), .conv2_wr_bank_o(conv2_wr_bank_o),
    .conv2_wr_addr_o(conv2_wr_addr_o), .conv2_wr_data_o(conv2_wr_data_o),
    .fc_wr_en_o(fc_wr_en_o), .fc_wr_bank_o(fc_wr_bank_o),
    .fc_wr_addr_o(fc_wr_addr_o), .fc_wr_data_o(fc_wr_data_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int T_CONV1 = 1;
  localparam int T_CONV2 = 2;
  localparam int T_FC    = 3;

  typedef struct {
    int           tgt;
    int           bank;
    int           addr;
    logic [103:0] data;
    int           cyc;
  } wr_t;

  wr_t wlog[$];
  int  cyc      = 0;
  int  hs_cyc   = -1;
  int  done_cnt = 0;
  int  err_cnt  = 0;
  int  multi_en = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (int'(conv1_wr_en_o) + int'(conv2_wr_en_o) + int'(fc_wr_en_o) > 1) multi_en++;
      if (conv1_wr_en_o)
        wlog.push_back('{T_CONV1, int'(conv1_wr_bank_o), int'(conv1_wr_addr_o), conv1_wr_data_o, cyc});
      if (conv2_wr_en_o)
        wlog.push_back('{T_CONV2, int'(conv2_wr_bank_o), int'(conv2_wr_addr_o), 104'(conv2_wr_data_o), cyc});
      if (fc_wr_en_o)
        wlog.push_back('{T_FC, int'(fc_wr_bank_o), int'(fc_wr_addr_o), 104'(fc_wr_data_o), cyc});
      if (word_valid_i && word_ready_o) hs_cyc = cyc;
      if (done_o) done_cnt++;
      if (err_o)  err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input int i, input int tgt, input int bank, input int addr,
                          input logic [103:0] data);
    if (i < wlog.size()) begin
      check($sformatf("wr%0d_tgt", i),  wlog[i].tgt,  tgt);
      check($sformatf("wr%0d_bank", i), wlog[i].bank, bank);
      check($sformatf("wr%0d_addr", i), wlog[i].addr, addr);
      check($sformatf("wr%0d_data", i), wlog[i].data, data);
    end else begin
      check($sformatf("wr%0d_missing", i), wlog.size(), i + 1);
    end
  endtask

  task automatic clear_log();
    wlog.delete();
    done_cnt = 0;
    err_cnt  = 0;
    hs_cyc   = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i        = 1'b1;
    cmd_valid_i  = 1'b0;
    word_valid_i = 1'b0;
    tick(2);
    rst_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [11:0] addr, input logic [9:0] count);
    logic rdy;
    int   n;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = addr;
    cmd_count_i = count;
    n = 0;
    do begin
      rdy = cmd_ready_o;
      tick(1);
      n++;
    end while (!rdy && n < 50);
    cmd_valid_i = 1'b0;
    if (!rdy) check("cmd_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [31:0] data, input int gap);
    logic rdy;
    int   n;
    word_valid_i = 1'b0;
    if (gap > 0) tick(gap);
    word_valid_i = 1'b1;
    word_data_i  = data;
    n = 0;
    do begin
      rdy = word_ready_o;
      tick(1);
      n++;
    end while (!rdy && n < 50);
    word_valid_i = 1'b0;
    if (!rdy) check("word_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 50) begin
      tick(1);
      n++;
    end
    if (busy_o) check("idle_timeout", 0, 1);
    tick(2);
  endtask

  initial begin
    cmd_addr_i  = '0;
    cmd_count_i = '0;
    word_data_i = '0;
    do_reset();

    // Reset state
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_word_ready", word_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_flags", {done_o, err_o, conv1_wr_en_o, conv2_wr_en_o, fc_wr_en_o}, 0);

    // Words offered in IDLE are not consumed
    word_valid_i = 1'b1;
    word_data_i  = 32'h0BADF00D;
    tick(1);
    check("idle_word_ready", word_ready_o, 0);
    word_valid_i = 1'b0;

    // 1: single fc entry
    clear_log();
    send_cmd(12'h300, 10'd1);
    check("t1_busy", busy_o, 1);
    send_word(32'hDEADBEEF, 0);
    wait_idle();
    check("t1_nwr", wlog.size(), 1);
    check_wr(0, T_FC, 2, 8'h00, 104'hDEADBEEF);
    if (wlog.size() > 0) check("t1_latency", wlog[0].cyc - hs_cyc, 1);
    check("t1_done", done_cnt, 1);
    check("t1_err", err_cnt, 0);

    // 2: conv1 entry, 4 words, back to back
    clear_log();
    send_cmd(12'h012, 10'd1);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    send_word(32'h33333333, 0);
    send_word(32'hAABBCCDD, 0);
    wait_idle();
    check("t2_nwr", wlog.size(), 1);
    check_wr(0, T_CONV1, 1, 2, {8'hDD, 32'h33333333, 32'h22222222, 32'h11111111});
    if (wlog.size() > 0) check("t2_latency", wlog[0].cyc - hs_cyc, 1);
    check("t2_done", done_cnt, 1);

    // 3: range wrap 0x08F -> 0x090 -> 0x100
    clear_log();
    send_cmd(12'h08F, 10'd3);
    send_word(32'hA0000001, 0);
    send_word(32'hA0000002, 0);
    send_word(32'hB0000001, 0);
    send_word(32'hB0000002, 0);
    send_word(32'hC0000001, 0);
    wait_idle();
    check("t3_nwr", wlog.size(), 3);
    check_wr(0, T_CONV2, 3, 4'hF, 104'hA0000002_A0000001);
    check_wr(1, T_CONV2, 4, 0,    104'hB0000002_B0000001);
    check_wr(2, T_FC,    0, 0,    104'hC0000001);
    check("t3_done", done_cnt, 1);
    check("t3_err", err_cnt, 0);

    // 4a: invalid address; err appears the cycle after the handshake
    clear_log();
    send_cmd(12'h008, 10'd1);
    check("t4a_err_now", err_o, 1);
    check("t4a_busy", busy_o, 0);
    tick(3);
    check("t4a_err_cnt", err_cnt, 1);
    check("t4a_nwr", wlog.size(), 0);

    // 4b: zero count
    clear_log();
    send_cmd(12'h000, 10'd0);
    tick(3);
    check("t4b_err_cnt", err_cnt, 1);
    check("t4b_busy", busy_o, 0);

    // 4c: overrun past 0x400
    clear_log();
    send_cmd(12'h400, 10'd2);
    send_word(32'h12345678, 0);
    wait_idle();
    check("t4c_nwr", wlog.size(), 1);
    check_wr(0, T_FC, 3, 0, 104'h12345678);
    check("t4c_err", err_cnt, 1);
    check("t4c_done", done_cnt, 0);

    // 5: back-pressure on a 4-entry conv2 load
    clear_log();
    send_cmd(12'h050, 10'd4);
    for (int k = 0; k < 4; k++) begin
      send_word(32'h50000000 | (k << 8) | 32'h0, $urandom_range(0, 3));
      send_word(32'h50000000 | (k << 8) | 32'h1, $urandom_range(0, 3));
    end
    wait_idle();
    check("t5_nwr", wlog.size(), 4);
    for (int k = 0; k < 4; k++)
      check_wr(k, T_CONV2, 0, k, {40'h0, 32'h50000001 | (k << 8), 32'h50000000 | (k << 8)});
    check("t5_done", done_cnt, 1);

    // 6: reset after 2 of 4 conv1 words
    clear_log();
    send_cmd(12'h000, 10'd1);
    send_word(32'hBAD00000, 0);
    send_word(32'hBAD00001, 0);
    do_reset();
    check("t6_busy", busy_o, 0);
    check("t6_cmd_ready", cmd_ready_o, 1);
    tick(3);
    check("t6_nwr_after_rst", wlog.size(), 0);
    send_cmd(12'h000, 10'd1);
    send_word(32'h01020304, 0);
    send_word(32'h05060708, 1);
    send_word(32'h090A0B0C, 0);
    send_word(32'hFFFFFF0D, 2);
    wait_idle();
    check("t6_nwr", wlog.size(), 1);
    check_wr(0, T_CONV1, 0, 0, {8'h0D, 32'h090A0B0C, 32'h05060708, 32'h01020304});
    check("t6_done", done_cnt, 1);

    check("one_hot_wr_en", multi_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
